data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the MIPS core's data port. It accepts one word-sized load or store request at a time and services it against an internal byte-lane memory after a fixed, parameterised latency. It returns read data on the same four-byte-lane layout the core uses. It sits between the core's data-memory interface and the rest of the system; the bench models it as the data memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; legal word index is 0 .. DEPTH_WORDS-1.
- LATENCY, 2: cycles from request accept to response; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_addr  input  32  byte address.
- req_we  input  1  1 = store, 0 = load.
- req_wdata  input  8 x [0:3]  store data; lane i holds byte address addr+i.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  8 x [0:3]  load data, same lane order as req_wdata.
- rsp_err  output  1  qualified by rsp_valid; misaligned or out-of-range request.

## Operation
- Lane order is big-endian: word value = {lane0, lane1, lane2, lane3}, and lane0 is at byte addr+0.
- States:
  - IDLE: req_ready=1. If req_valid, latch addr, we and wdata, load the counter with LATENCY-1, and go to WAIT. If LATENCY=1, go directly to RESP.
  - WAIT: decrement the counter each cycle. When the counter reaches 0, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- Access check uses the latched address. Error if addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
- Store, no error: all four lanes are written on the clock edge that ends the RESP cycle. rsp_rdata = 0.
- Load, no error: rsp_rdata = memory word at addr[31:2], read in the RESP cycle.
- Any error: memory is unchanged, rsp_rdata = 0, rsp_err=1.
- Requests are strictly sequential. A load issued after a store's RESP sees the stored data.
- There is no response backpressure. The requester must consume rsp_valid in that cycle.
- req_* inputs are ignored outside an IDLE accept cycle.

## Timing
- Accept happens in cycle T (req_valid and req_ready both high at the rising edge ending T).
- rsp_valid is high in cycle T+LATENCY. req_ready returns high in cycle T+LATENCY+1.
- Throughput is one request per LATENCY+1 cycles.
- Values while rst is high and in the first cycle after it (state IDLE):
  - req_ready=1 in the first cycle after reset.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - The counter is 0.
- Memory contents are not reset.
- Reset mid-operation, in WAIT or RESP: the in-flight request is dropped and no response is produced.
  - If rst is high in a store's RESP cycle, the write does not commit; reset has priority.
- rsp_rdata and rsp_err hold 0 in every cycle where rsp_valid=0.
- Counter width is 4 bits. It must never underflow; it only decrements in WAIT.

## Structure
- Shared package mem_pkg holds:
  - byte_t (8-bit logic);
  - LANES = 4;
  - the state enum {IDLE, WAIT, RESP};
  - the word_lanes_t typedef (byte_t [0:LANES-1]), reused by the core side.
- One sub-module, mem_byte_bank, holds DEPTH_WORDS bytes with a registered-write, combinational-read port. It is instantiated once per lane.
- The top level holds the FSM, the latency counter, the request latch and the error check.

## Test plan
- Store then load, no errors (LATENCY=2): store addr 0x10, data lanes {0xDE,0xAD,0xBE,0xEF}.
  - Store: rsp_valid at T+2, err 0.
  - Load of 0x10: rsp_rdata {0xDE,0xAD,0xBE,0xEF} at T'+2.
- Misaligned store: store to 0x13 -> rsp_err=1, rsp_rdata=0. A later load of 0x10 still returns its prior word.
- Out-of-range load: load of address DEPTH_WORDS*4 (0x1000) -> rsp_err=1, rsp_rdata=0.
- Handshake under held request: req_valid held high for 6 cycles -> only one accept.
  - req_ready is low in cycles T+1..T+2 and high in T+3.
  - A second accept happens at T+3.
- Reset during a store: assert rst in the RESP cycle of a store to 0x20 -> no rsp_valid; the next load of 0x20 returns the old contents.
- LATENCY=1 build: load -> rsp_valid at T+1, req_ready high at T+2. Back-to-back loads every 2 cycles return the correct words.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the core data-memory interface: byte lanes, word layout and responder states.
package mem_pkg;

    localparam int unsigned LANES = 4;

    typedef logic [7:0] byte_t;

    // Lane 0 holds byte address addr+0; packed so lane 0 lands in the word's MSBs (big-endian).
    typedef byte_t [0:LANES-1] word_lanes_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mem_byte_bank.sv
// One byte lane of the data memory: registered write, combinational read, contents never reset.
module mem_byte_bank
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  byte_t         wdata,
    output byte_t         rdata
);

    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency, one-at-a-time load/store responder backed by four byte-lane banks.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  word_lanes_t req_wdata,
    output logic        rsp_valid,
    output word_lanes_t rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    word_lanes_t   wdata_q, wdata_d;

    logic          err_c;
    logic          mem_we_c;
    word_lanes_t   mem_rdata_c;

    // State, counter and request latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state; the counter is loaded on accept and only counts down in WAIT, stopping at zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                if (cnt_q <= CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign err_c = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));

    // Outputs; reset suppresses the response and blocks a pending store commit
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        mem_we_c  = 1'b0;
        if (rst) begin
            req_ready = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: req_ready = 1'b1;
                RESP: begin
                    rsp_valid = 1'b1;
                    rsp_err   = err_c;
                    if (!err_c) begin
                        if (we_q) begin
                            mem_we_c = 1'b1;
                        end else begin
                            rsp_rdata = mem_rdata_c;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mem_byte_bank #(
            .DEPTH (DEPTH_WORDS),
            .AW    (AW)
        ) u_bank (
            .clk   (clk),
            .we    (mem_we_c),
            .addr  (addr_q[AW+1:2]),
            .wdata (wdata_q[i]),
            .rdata (mem_rdata_c[i])
        );
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded bench for data_mem_responder: a LATENCY=2 instance (a) and a LATENCY=1 instance (b).
module tb_data_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        valid_a, valid_b, we_a, we_b;
    logic [31:0] addr_a, addr_b;
    word_lanes_t wd_a, wd_b;
    logic        rdy_a, rdy_b, rv_a, rv_b, err_a, err_b;
    word_lanes_t rd_a, rd_b;

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0] q_a[$];
    logic [32:0] q_b[$];
    logic [32:0] mon_exp_a, mon_exp_b;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_a (
        .clk(clk), .rst(rst_a), .req_valid(valid_a), .req_ready(rdy_a), .req_addr(addr_a),
        .req_we(we_a), .req_wdata(wd_a), .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst_b), .req_valid(valid_b), .req_ready(rdy_b), .req_addr(addr_b),
        .req_we(we_b), .req_wdata(wd_b), .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b)
    );

    // Scoreboard pop for instance a; idle cycles must show zero data/err
    always @(negedge clk) begin
        if (rst_a !== 1'b1) begin
            vectors++;
            if (rv_a === 1'b1) begin
                if (q_a.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected_a: rsp_valid=1 with no request outstanding at %0t", $time);
                end else begin
                    mon_exp_a = q_a.pop_front();
                    if ({err_a, 32'(rd_a)} !== mon_exp_a) begin
                        miscompares++;
                        $display("FAIL rsp_data_a: got err=%b rdata=%h, expected err=%b rdata=%h",
                                 err_a, 32'(rd_a), mon_exp_a[32], mon_exp_a[31:0]);
                    end
                end
            end else if ({err_a, 32'(rd_a)} !== 33'd0) begin
                miscompares++;
                $display("FAIL idle_zero_a: got err=%b rdata=%h, expected 0/0", err_a, 32'(rd_a));
            end
        end
    end

    // Scoreboard pop for instance b
    always @(negedge clk) begin
        if (rst_b !== 1'b1) begin
            vectors++;
            if (rv_b === 1'b1) begin
                if (q_b.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected_b: rsp_valid=1 with no request outstanding at %0t", $time);
                end else begin
                    mon_exp_b = q_b.pop_front();
                    if ({err_b, 32'(rd_b)} !== mon_exp_b) begin
                        miscompares++;
                        $display("FAIL rsp_data_b: got err=%b rdata=%h, expected err=%b rdata=%h",
                                 err_b, 32'(rd_b), mon_exp_b[32], mon_exp_b[31:0]);
                    end
                end
            end else if ({err_b, 32'(rd_b)} !== 33'd0) begin
                miscompares++;
                $display("FAIL idle_zero_b: got err=%b rdata=%h, expected 0/0", err_b, 32'(rd_b));
            end
        end
    end

    task automatic drive(input bit sel, input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] d);
        if (sel) begin
            valid_b = v; addr_b = a; we_b = w; wd_b = d;
        end else begin
            valid_a = v; addr_a = a; we_a = w; wd_a = d;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? rdy_b : rdy_a;
    endfunction

    function automatic logic vld(input bit sel);
        return sel ? rv_b : rv_a;
    endfunction

    // Single request: checks accept, response latency and req_ready return; data checked by scoreboard
    task automatic issue(input bit sel, input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic exp_err, input logic [31:0] exp_rdata);
        int lat;
        bit seen;
        lat  = sel ? 1 : 2;
        seen = 1'b0;
        drive(sel, 1'b1, a, w, d);
        if (sel) q_b.push_back({exp_err, exp_rdata});
        else     q_a.push_back({exp_err, exp_rdata});
        @(negedge clk);
        vectors++;
        if (rdy(sel) !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready_%0d: req_ready=%b, expected 1 (addr %h)", sel, rdy(sel), a);
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int k = 1; k <= 16 && !seen; k++) begin
            @(negedge clk);
            if (vld(sel) === 1'b1) begin
                seen = 1'b1;
                vectors++;
                if (k != lat) begin
                    miscompares++;
                    $display("FAIL latency_%0d: rsp_valid at T+%0d, expected T+%0d (addr %h)", sel, k, lat, a);
                end
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout_%0d: no rsp_valid within 16 cycles, expected T+%0d (addr %h)", sel, lat, a);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (rdy(sel) !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_return_%0d: req_ready=%b at T+%0d, expected 1", sel, rdy(sel), lat + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        vectors += 2;
        if ({rdy_a, rv_a, err_a, 32'(rd_a)} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL in_reset_a: ready=%b valid=%b err=%b rdata=%h, expected 1 0 0 0", rdy_a, rv_a, err_a, 32'(rd_a));
        end
        if ({rdy_b, rv_b, err_b, 32'(rd_b)} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL in_reset_b: ready=%b valid=%b err=%b rdata=%h, expected 1 0 0 0", rdy_b, rv_b, err_b, 32'(rd_b));
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        vectors += 2;
        if ({rdy_a, rv_a} !== 2'b10) begin
            miscompares++;
            $display("FAIL post_reset_a: ready=%b valid=%b, expected 1 0", rdy_a, rv_a);
        end
        if ({rdy_b, rv_b} !== 2'b10) begin
            miscompares++;
            $display("FAIL post_reset_b: ready=%b valid=%b, expected 1 0", rdy_b, rv_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        issue(1'b0, 32'h10, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0);
        issue(1'b0, 32'h10, 1'b0, 32'd0,        1'b0, 32'hDEADBEEF);
        issue(1'b0, 32'h14, 1'b1, 32'h0102A5F0, 1'b0, 32'd0);
        issue(1'b0, 32'h14, 1'b0, 32'd0,        1'b0, 32'h0102A5F0);
        issue(1'b0, 32'h10, 1'b0, 32'd0,        1'b0, 32'hDEADBEEF);
    endtask

    task automatic test_misaligned();
        issue(1'b0, 32'h13, 1'b1, 32'h11223344, 1'b1, 32'd0);
        issue(1'b0, 32'h10, 1'b0, 32'd0,        1'b0, 32'hDEADBEEF);
        issue(1'b0, 32'h11, 1'b0, 32'd0,        1'b1, 32'd0);
        issue(1'b0, 32'h16, 1'b1, 32'h55667788, 1'b1, 32'd0);
        issue(1'b0, 32'h14, 1'b0, 32'd0,        1'b0, 32'h0102A5F0);
    endtask

    task automatic test_out_of_range();
        issue(1'b0, 32'h1000,     1'b0, 32'd0,        1'b1, 32'd0);
        issue(1'b0, 32'hFFC,      1'b1, 32'h600DF00D, 1'b0, 32'd0);
        issue(1'b0, 32'hFFC,      1'b0, 32'd0,        1'b0, 32'h600DF00D);
        issue(1'b0, 32'h1000,     1'b1, 32'hBAD0BAD0, 1'b1, 32'd0);
        issue(1'b0, 32'h8000_0010, 1'b1, 32'hBAD1BAD1, 1'b1, 32'd0);
        issue(1'b0, 32'h10,       1'b0, 32'd0,        1'b0, 32'hDEADBEEF);
    endtask

    // req_valid held for 6 cycles: accepts at T and T+3 only
    task automatic test_held_request();
        logic exp_rdy;
        drive(1'b0, 1'b1, 32'h10, 1'b0, 32'd0);
        q_a.push_back({1'b0, 32'hDEADBEEF});
        q_a.push_back({1'b0, 32'hDEADBEEF});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_rdy = (c == 0 || c == 3);
            vectors++;
            if (rdy_a !== exp_rdy) begin
                miscompares++;
                $display("FAIL held_ready: req_ready=%b at T+%0d, expected %b", rdy_a, c, exp_rdy);
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        vectors++;
        if (rdy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL held_ready_end: req_ready=%b at T+6, expected 1", rdy_a);
        end
        @(posedge clk); #1;
    endtask

    // Reset in a store's RESP cycle drops the response and the write
    task automatic test_reset_mid_store();
        issue(1'b0, 32'h20, 1'b1, 32'hA1B2C3D4, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h0BADCAFE);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rv_a, rdy_a} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_in_resp: valid=%b ready=%b, expected 0 1", rv_a, rdy_a);
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({rv_a, rdy_a} !== 2'b01) begin
                miscompares++;
                $display("FAIL after_reset_drop: valid=%b ready=%b cycle %0d, expected 0 1", rv_a, rdy_a, c);
            end
        end
        @(posedge clk); #1;
        issue(1'b0, 32'h20, 1'b0, 32'd0, 1'b0, 32'hA1B2C3D4);
    endtask

    // LATENCY=1 instance: single transactions then loads every 2 cycles
    task automatic test_latency_one();
        logic [31:0] addrs [4];
        logic [31:0] words [4];
        issue(1'b1, 32'h0,   1'b1, 32'hCAFEF00D, 1'b0, 32'd0);
        issue(1'b1, 32'h4,   1'b1, 32'h01234567, 1'b0, 32'd0);
        issue(1'b1, 32'hFFC, 1'b1, 32'h89ABCDEF, 1'b0, 32'd0);
        issue(1'b1, 32'h0,   1'b0, 32'd0,        1'b0, 32'hCAFEF00D);
        issue(1'b1, 32'h1000, 1'b0, 32'd0,       1'b1, 32'd0);
        addrs[0] = 32'h4;   words[0] = 32'h01234567;
        addrs[1] = 32'h0;   words[1] = 32'hCAFEF00D;
        addrs[2] = 32'hFFC; words[2] = 32'h89ABCDEF;
        addrs[3] = 32'h4;   words[3] = 32'h01234567;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, addrs[i], 1'b0, 32'd0);
            q_b.push_back({1'b0, words[i]});
            @(negedge clk);
            vectors++;
            if (rdy_b !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready: req_ready=%b before load %0d, expected 1", rdy_b, i);
            end
            @(posedge clk); #1;
            @(negedge clk);
            vectors++;
            if ({rv_b, rdy_b} !== 2'b10) begin
                miscompares++;
                $display("FAIL b2b_resp: valid=%b ready=%b after load %0d, expected 1 0", rv_b, rdy_b, i);
            end
            @(posedge clk); #1;
        end
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_held_request();
        test_reset_mid_store();
        test_latency_one();
        for (int c = 0; c < 50 && (q_a.size() != 0 || q_b.size() != 0); c++) begin
            @(posedge clk);
        end
        vectors++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d responses outstanding, expected 0/0", q_a.size(), q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
